// File: rtl/trdb_apb_bridge.sv
// APB slave bridge fanning one APB port out to NUM_TARGETS valid/ready register targets.
// Decodes the target from the upper address bits, waits for the target, and registers the response.
module trdb_apb_bridge #(
    parameter int APB_ADDR_WIDTH = 12,
    parameter int TGT_ADDR_WIDTH = 8,
    parameter int NUM_TARGETS    = 2,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic [APB_ADDR_WIDTH-1:0]   paddr,
    input  logic [31:0]                 pwdata,
    input  logic                        pwrite,
    input  logic                        psel,
    input  logic                        penable,
    output logic [31:0]                 prdata,
    output logic                        pready,
    output logic                        pslverr,
    input  logic [32*NUM_TARGETS-1:0]   per_rdata_i,
    input  logic [NUM_TARGETS-1:0]      per_ready_i,
    output logic [31:0]                 per_wdata_o,
    output logic [TGT_ADDR_WIDTH-1:0]   per_addr_o,
    output logic                        per_we_o,
    output logic [NUM_TARGETS-1:0]      per_valid_o
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_RESP
    } state_e;

    state_e                      state_q, state_d;
    logic [TGT_ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [31:0]                 wdata_q, wdata_d;
    logic                        we_q, we_d;
    logic [NUM_TARGETS-1:0]      valid_q, valid_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [31:0]                 prdata_q, prdata_d;
    logic                        pready_q, pready_d;
    logic                        pslverr_q, pslverr_d;

    logic [31:0]                 dec_idx;
    logic                        dec_hit;
    logic [NUM_TARGETS-1:0]      dec_onehot;
    logic [31:0]                 rdata_masked [NUM_TARGETS];
    logic [31:0]                 sel_rdata;
    logic                        sel_ready;

    assign dec_idx = 32'(paddr[APB_ADDR_WIDTH-1:TGT_ADDR_WIDTH]);
    assign dec_hit = (dec_idx < 32'(NUM_TARGETS));

    // The one-hot valid register doubles as the response mux select, so
    // ready/rdata of non-selected targets never reach the response path.
    generate
        for (genvar gi = 0; gi < NUM_TARGETS; gi++) begin : g_tgt
            assign dec_onehot[gi]   = (dec_idx == 32'(gi));
            assign rdata_masked[gi] = valid_q[gi] ? per_rdata_i[32*gi +: 32] : 32'h0;
        end
    endgenerate

    assign sel_ready = |(per_ready_i & valid_q);

    always_comb begin
        sel_rdata = 32'h0;
        for (int k = 0; k < NUM_TARGETS; k++) begin
            sel_rdata = sel_rdata | rdata_masked[k];
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        we_d      = we_q;
        valid_d   = valid_q;
        cnt_d     = cnt_q;
        prdata_d  = prdata_q;
        pready_d  = 1'b0;
        pslverr_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (psel && penable) begin
                    if (dec_hit) begin
                        addr_d  = paddr[TGT_ADDR_WIDTH-1:0];
                        wdata_d = pwdata;
                        we_d    = pwrite;
                        valid_d = dec_onehot;
                        cnt_d   = '0;
                        state_d = ST_ACCESS;
                    end else begin
                        prdata_d  = 32'h0;
                        pready_d  = 1'b1;
                        pslverr_d = 1'b1;
                        state_d   = ST_RESP;
                    end
                end
            end
            ST_ACCESS: begin
                if (!psel) begin
                    valid_d = '0;
                    state_d = ST_IDLE;
                end else if (sel_ready) begin
                    // A ready arriving on the last counted cycle still wins over the timeout.
                    prdata_d  = we_q ? 32'h0 : sel_rdata;
                    pready_d  = 1'b1;
                    pslverr_d = 1'b0;
                    valid_d   = '0;
                    state_d   = ST_RESP;
                end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST)) begin
                    prdata_d  = 32'h0;
                    pready_d  = 1'b1;
                    pslverr_d = 1'b1;
                    valid_d   = '0;
                    state_d   = ST_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                valid_d = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            we_q      <= 1'b0;
            valid_q   <= '0;
            cnt_q     <= '0;
            prdata_q  <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            we_q      <= we_d;
            valid_q   <= valid_d;
            cnt_q     <= cnt_d;
            prdata_q  <= prdata_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
        end
    end

    assign prdata      = prdata_q;
    assign pready      = pready_q;
    assign pslverr     = pslverr_q;
    assign per_wdata_o = wdata_q;
    assign per_addr_o  = addr_q;
    assign per_we_o    = we_q;
    assign per_valid_o = valid_q;

endmodule

// File: tb/tb_trdb_apb_bridge.sv
// Randomized scoreboard bench for trdb_apb_bridge: stimulus queues expected responses,
// a monitor checks request-side signals every cycle and pops/compares on each pready.
module tb_trdb_apb_bridge;

    localparam int AW = 12;
    localparam int TW = 8;
    localparam int NT = 2;
    localparam int TO = 16;

    logic              clk_i = 1'b0;
    logic              rst_ni = 1'b0;
    logic [AW-1:0]     paddr = '0;
    logic [31:0]       pwdata = '0;
    logic              pwrite = 1'b0;
    logic              psel = 1'b0;
    logic              penable = 1'b0;
    logic [31:0]       prdata;
    logic              pready;
    logic              pslverr;
    logic [32*NT-1:0]  per_rdata_i = '0;
    logic [NT-1:0]     per_ready_i = '0;
    logic [31:0]       per_wdata_o;
    logic [TW-1:0]     per_addr_o;
    logic              per_we_o;
    logic [NT-1:0]     per_valid_o;

    trdb_apb_bridge #(
        .APB_ADDR_WIDTH(AW),
        .TGT_ADDR_WIDTH(TW),
        .NUM_TARGETS   (NT),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .paddr      (paddr),
        .pwdata     (pwdata),
        .pwrite     (pwrite),
        .psel       (psel),
        .penable    (penable),
        .prdata     (prdata),
        .pready     (pready),
        .pslverr    (pslverr),
        .per_rdata_i(per_rdata_i),
        .per_ready_i(per_ready_i),
        .per_wdata_o(per_wdata_o),
        .per_addr_o (per_addr_o),
        .per_we_o   (per_we_o),
        .per_valid_o(per_valid_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        bit          hit;
        int          idx;
        int          off;
        bit          we;
        logic [31:0] wdata;
        logic [31:0] prdata;
        bit          err;
        int          vcyc;
        int          lat;
        int          start;
    } txn_t;

    txn_t        exp_q[$];
    txn_t        cur;
    int          tgt_wait = 0;
    logic [31:0] tgt_rdata = '0;
    int          cyc = 0;
    int          n_chk = 0;
    int          n_fail = 0;
    int          n_txn = 0;

    always @(posedge clk_i) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_chk++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp_v, $time);
        end
    endfunction

    // Reference: what an APB master should observe for one transfer, given how long the target stalls.
    function automatic txn_t model(input int idx, input int off, input bit we,
                                   input logic [31:0] wd, input int w, input logic [31:0] rd);
        txn_t t;
        t.hit    = (idx < NT);
        t.idx    = idx;
        t.off    = off;
        t.we     = we;
        t.wdata  = wd;
        t.err    = !t.hit || (TO != 0 && w >= TO);
        t.prdata = (t.hit && !t.err && !we) ? rd : 32'h0;
        t.vcyc   = !t.hit ? 0 : (t.err ? TO : w + 1);
        t.lat    = !t.hit ? 1 : t.vcyc + 1;
        t.start  = 0;
        return t;
    endfunction

    function automatic void check_idle_outputs(input string tag);
        chk({tag, "_prdata"},  prdata, 32'h0);
        chk({tag, "_pready"},  32'(pready), 32'h0);
        chk({tag, "_pslverr"}, 32'(pslverr), 32'h0);
        chk({tag, "_wdata"},   per_wdata_o, 32'h0);
        chk({tag, "_addr"},    32'(per_addr_o), 32'h0);
        chk({tag, "_we"},      32'(per_we_o), 32'h0);
        chk({tag, "_valid"},   32'(per_valid_o), 32'h0);
    endfunction

    // Target model: selected target asserts ready on its (wait+1)-th valid cycle; other bits are noise.
    initial begin
        int vcnt;
        vcnt = 0;
        forever begin
            @(negedge clk_i);
            per_ready_i = NT'($urandom);
            per_rdata_i = {$urandom, $urandom};
            if (per_valid_o != '0) begin
                vcnt++;
                for (int k = 0; k < NT; k++) begin
                    if (per_valid_o[k]) begin
                        per_ready_i[k] = (vcnt == tgt_wait + 1);
                        per_rdata_i[32*k +: 32] = tgt_rdata;
                    end
                end
            end else begin
                vcnt = 0;
            end
        end
    end

    // Monitor / scoreboard.
    initial begin
        int   vrun;
        txn_t t;
        vrun = 0;
        forever begin
            @(negedge clk_i);
            if (pready) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_pready: got pready=1, expected no response (t=%0t)", $time);
                end else begin
                    t = exp_q.pop_front();
                    chk("prdata", prdata, t.prdata);
                    chk("pslverr", 32'(pslverr), 32'(t.err));
                    chk("latency", 32'(cyc - t.start), 32'(t.lat));
                    chk("valid_cycles", 32'(vrun), 32'(t.vcyc));
                    n_txn++;
                    $display("txn %0d idx=%0d off=0x%02h we=%0b prdata=0x%08h pslverr=%0b lat=%0d",
                             n_txn, t.idx, t.off, t.we, prdata, pslverr, cyc - t.start);
                end
                vrun = 0;
            end else if (per_valid_o != '0) begin
                vrun++;
                chk("per_valid_o", 32'(per_valid_o), cur.hit ? (32'h1 << cur.idx) : 32'h0);
                chk("per_addr_o", 32'(per_addr_o), 32'(cur.off));
                chk("per_we_o", 32'(per_we_o), 32'(cur.we));
                chk("per_wdata_o", per_wdata_o, cur.wdata);
            end else begin
                vrun = 0;
            end
        end
    end

    task automatic start_xfer(input int idx, input int off, input bit we,
                              input logic [31:0] wd, input int w, input logic [31:0] rd,
                              input bit expect_resp);
        txn_t t;
        t = model(idx, off, we, wd, w, rd);
        tgt_wait  = w;
        tgt_rdata = rd;
        cur       = t;
        paddr     = AW'(idx * (1 << TW) + off);
        pwrite    = we;
        pwdata    = wd;
        psel      = 1'b1;
        penable   = 1'b0;
        @(posedge clk_i);
        #1;
        penable = 1'b1;
        t.start = cyc;
        if (expect_resp) exp_q.push_back(t);
    endtask

    task automatic apb(input int idx, input int off, input bit we,
                       input logic [31:0] wd, input int w, input logic [31:0] rd);
        bit got;
        start_xfer(idx, off, we, wd, w, rd, 1'b1);
        got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_i);
            if (pready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            n_chk++;
            n_fail++;
            $display("FAIL pready_timeout: got no pready in 100 cycles, expected a response");
            exp_q.delete();
        end
        @(posedge clk_i);
        #1;
        psel    = 1'b0;
        penable = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no end of test, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int idx, off, w, r;
        cur = model(0, 0, 1'b0, 32'h0, 0, 32'h0);

        repeat (3) @(negedge clk_i);
        check_idle_outputs("reset");
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;

        // Directed cases
        apb(1, 8'h04, 1'b0, 32'h0, 0, 32'hDEADBEEF);
        apb(0, 8'h10, 1'b1, 32'h12345678, 3, 32'hCAFEF00D);
        apb(2, 8'h00, 1'b0, 32'h0, 0, 32'h11111111);
        apb(0, 8'h20, 1'b0, 32'h0, 1000, 32'h22222222);
        apb(1, 8'h30, 1'b0, 32'h0, TO - 1, 32'h33333333);
        apb(1, 8'h34, 1'b1, 32'hA5A5A5A5, TO, 32'h44444444);
        apb(15, 8'hFF, 1'b1, 32'h55555555, 0, 32'h0);

        // Randomized traffic
        for (int n = 0; n < 150; n++) begin
            r   = $urandom_range(0, 9);
            idx = (r < 8) ? (r % NT) : $urandom_range(NT, (1 << (AW - TW)) - 1);
            off = $urandom_range(0, (1 << TW) - 1);
            r   = $urandom_range(0, 9);
            w   = (r < 7) ? $urandom_range(0, 4) : $urandom_range(TO - 2, TO + 1);
            apb(idx, off, 1'($urandom), $urandom, w, $urandom);
        end

        // psel dropped mid-ACCESS: valid clears, no response
        start_xfer(0, 8'h40, 1'b0, 32'h0, 1000, 32'h66666666, 1'b0);
        repeat (3) @(posedge clk_i);
        #1;
        psel    = 1'b0;
        penable = 1'b0;
        @(posedge clk_i);
        #1;
        chk("abort_valid_clear", 32'(per_valid_o), 32'h0);
        repeat (4) @(posedge clk_i);
        #1;

        // Asynchronous reset in the second ACCESS cycle
        start_xfer(1, 8'h50, 1'b1, 32'h77777777, 10, 32'h0, 1'b0);
        repeat (2) @(posedge clk_i);
        #1;
        chk("valid_before_rst", 32'(per_valid_o), 32'h2);
        #1;
        rst_ni = 1'b0;
        #1;
        check_idle_outputs("async_rst");
        psel    = 1'b0;
        penable = 1'b0;
        @(posedge clk_i);
        #3;
        rst_ni = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        apb(1, 8'h08, 1'b0, 32'h0, 2, 32'h0BADC0DE);

        repeat (3) @(posedge clk_i);
        chk("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
        $finish;
    end

endmodule
